// File: rtl/mapper_sst_pkg.sv
// Shared types and constants for the mapper save-state sequencer.
package mapper_sst_pkg;

  localparam int SST_DATA_W        = 8;
  localparam int SST_DEFAULT_SLOTS = 64;

  typedef enum logic [2:0] {
    IDLE,
    RD_SET,
    RD_OUT,
    WR_WAIT,
    WR_HLD,
    FIN
  } sst_state_e;

endpackage

// File: rtl/mapper_sst_sequencer.sv
// Mapper save-state sequencer.
// SAVE reads slots 0..SLOTS-1 through the mapper save-state port and streams
// them out over a valid/ready link. LOAD takes a byte stream and writes each
// byte into the matching slot, holding the write strobe long enough for the
// slower mapper clock domain. Every port is driven straight from a flop.
module mapper_sst_sequencer
  import mapper_sst_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int SLOTS     = SST_DEFAULT_SLOTS,
  parameter int RD_SETTLE = 2,
  parameter int WR_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_save,
  input  logic                  cmd_load,
  input  logic                  cmd_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cmd_err,
  output logic [SST_DATA_W-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [SST_DATA_W-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  sst_enable,
  output logic                  sst_we,
  output logic [ADDR_W-1:0]     sst_addr,
  output logic [SST_DATA_W-1:0] sst_data_in,
  input  logic [SST_DATA_W-1:0] sst_data_out
);

  // One down-counter serves both the read settle time and the write hold time.
  localparam int HOLD_MAX = (RD_SETTLE > WR_HOLD) ? RD_SETTLE : WR_HOLD;
  localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  localparam logic [HOLD_W-1:0] RD_LOAD   = HOLD_W'(RD_SETTLE - 1);
  localparam logic [HOLD_W-1:0] WR_LOAD   = HOLD_W'(WR_HOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(SLOTS - 1);

  sst_state_e            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [SST_DATA_W-1:0] out_data_q, out_data_d;
  logic [SST_DATA_W-1:0] sst_data_in_q, sst_data_in_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  sst_we_q, sst_we_d;

  // Next-state, counters, captured data and the registered strobes.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    hold_d        = hold_q;
    out_data_d    = out_data_q;
    sst_data_in_d = sst_data_in_q;
    aborted_d     = 1'b0;
    cmd_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_save && cmd_load) begin
          cmd_err_d = 1'b1;
        end else if (cmd_save) begin
          state_d = RD_SET;
          addr_d  = '0;
          hold_d  = RD_LOAD;
        end else if (cmd_load) begin
          state_d = WR_WAIT;
          addr_d  = '0;
        end
      end
      RD_SET: begin
        if (hold_q == '0) begin
          out_data_d = sst_data_out;
          state_d    = RD_OUT;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RD_OUT: begin
        if (out_ready) begin
          if (addr_q == LAST_SLOT) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            hold_d  = RD_LOAD;
            state_d = RD_SET;
          end
        end
      end
      WR_WAIT: begin
        if (in_valid) begin
          sst_data_in_d = in_data;
          hold_d        = WR_LOAD;
          state_d       = WR_HLD;
        end
      end
      WR_HLD: begin
        if (hold_q == '0) begin
          if (addr_q == LAST_SLOT) begin
            state_d = FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = WR_WAIT;
          end
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Commands while a transfer runs: start requests are rejected, abort
    // returns to IDLE and overrides whatever the state above decided,
    // including a pending FIN.
    if (state_q != IDLE) begin
      if (cmd_save || cmd_load) begin
        cmd_err_d = 1'b1;
      end
      if (cmd_abort) begin
        state_d   = IDLE;
        hold_d    = '0;
        aborted_d = 1'b1;
      end
    end

    // Strobes are decoded from the next state so the flopped copies line up
    // with the state they describe.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    out_valid_d = (state_d == RD_OUT);
    in_ready_d  = (state_d == WR_WAIT);
    sst_we_d    = (state_d == WR_HLD);
  end

  // State, counters and all output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      hold_q        <= '0;
      out_data_q    <= '0;
      sst_data_in_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      sst_we_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q       <= state_d;
      addr_q        <= addr_d;
      hold_q        <= hold_d;
      out_data_q    <= out_data_d;
      sst_data_in_q <= sst_data_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      cmd_err_q     <= cmd_err_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      sst_we_q      <= sst_we_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;
  assign cmd_err     = cmd_err_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign in_ready    = in_ready_q;
  assign sst_enable  = busy_q;
  assign sst_we      = sst_we_q;
  assign sst_addr    = addr_q;
  assign sst_data_in = sst_data_in_q;

endmodule

// File: tb/tb_mapper_sst_sequencer.sv
// Self-checking bench for mapper_sst_sequencer with a behavioural mapper
// (64 byte registers) and expectations taken from the transfer rules.
module tb_mapper_sst_sequencer;

  localparam int ADDR_W    = 6;
  localparam int SLOTS     = 11;
  localparam int RD_SETTLE = 2;
  localparam int WR_HOLD   = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_save = 1'b0, cmd_load = 1'b0, cmd_abort = 1'b0;
  logic              busy, done, aborted, cmd_err;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              sst_enable, sst_we;
  logic [ADDR_W-1:0] sst_addr;
  logic [7:0]        sst_data_in, sst_data_out;

  mapper_sst_sequencer #(
    .ADDR_W(ADDR_W), .SLOTS(SLOTS), .RD_SETTLE(RD_SETTLE), .WR_HOLD(WR_HOLD)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_save(cmd_save), .cmd_load(cmd_load), .cmd_abort(cmd_abort),
    .busy(busy), .done(done), .aborted(aborted), .cmd_err(cmd_err),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sst_enable(sst_enable), .sst_we(sst_we), .sst_addr(sst_addr),
    .sst_data_in(sst_data_in), .sst_data_out(sst_data_out)
  );

  always #5 clk = ~clk;

  // ---------------- mapper model ----------------
  logic [7:0] regs [64];
  logic [7:0] preset_vals [64];
  logic       preset_req = 1'b0;

  assign sst_data_out = regs[sst_addr];

  always @(posedge clk) begin
    if (preset_req) begin
      for (int k = 0; k < 64; k++) regs[k] <= preset_vals[k];
    end else if (sst_enable && sst_we) begin
      regs[sst_addr] <= sst_data_in;
    end
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         rx_t [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int         hold_viol = 0;
  int         we_cnt [64];
  int         done_cnt = 0;

  initial for (int k = 0; k < 64; k++) we_cnt[k] = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rx_q.push_back(out_data);
      rx_t.push_back(cyc);
    end
    if (stall_q && out_valid && (out_data != stall_data)) hold_viol <= hold_viol + 1;
    stall_q    <= out_valid && !out_ready;
    stall_data <= out_data;
    if (sst_we) we_cnt[sst_addr] <= we_cnt[sst_addr] + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {2'b00, busy, done, aborted, cmd_err, out_valid, in_ready, sst_enable,
            sst_we, sst_addr, sst_data_in, out_data};
  endfunction

  task automatic preset(input bit rnd);
    for (int k = 0; k < 64; k++) preset_vals[k] = rnd ? 8'($urandom) : 8'(8'hA0 + k);
    @(posedge clk); #1;
    preset_req = 1'b1;
    @(posedge clk); #1;
    preset_req = 1'b0;
  endtask

  // One-cycle command pulse; returns at the negedge after the DUT saw it.
  task automatic pulse(input bit s, input bit l, input bit a);
    @(posedge clk); #1;
    cmd_save = s; cmd_load = l; cmd_abort = a;
    @(posedge clk); #1;
    cmd_save = 1'b0; cmd_load = 1'b0; cmd_abort = 1'b0;
    @(negedge clk);
  endtask

  int end_cyc;

  // Wait (bounded) for done or aborted, optionally toggling out_ready.
  task automatic wait_end(input int budget, input bit rand_ready,
                          output bit got_done, output bit got_abort);
    got_done  = 1'b0;
    got_abort = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
      if (aborted) got_abort = 1'b1;
      if (got_done || got_abort) begin
        end_cyc = cyc;
        break;
      end
      if (rand_ready) begin
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Compare the SAVE stream captured since 'base' against the preset image.
  task automatic check_stream(input string tag, input int base);
    check({tag, "_count"}, rx_q.size() - base, SLOTS);
    for (int k = 0; k < SLOTS; k++) begin
      if (base + k < rx_q.size()) check({tag, "_byte"}, rx_q[base + k], preset_vals[k]);
    end
  endtask

  bit we_at_abort;

  // Drive a LOAD of bytes 8'h10+i; abort_at>0 asserts cmd_abort right after
  // that many bytes were accepted.
  task automatic run_load(input int abort_at, output bit got_done, output bit got_abort);
    int  idx;
    bit  hs;
    bit  abort_pending;
    idx = 0;
    abort_pending = 1'b0;
    got_done  = 1'b0;
    got_abort = 1'b0;
    in_data  = 8'h10;
    in_valid = 1'b1;
    pulse(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (abort_pending) we_at_abort = sst_we;
      if (done) got_done = 1'b1;
      if (aborted) got_abort = 1'b1;
      if (got_done || got_abort) break;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cmd_abort = 1'b0;
      abort_pending = 1'b0;
      if (hs) begin
        idx++;
        if (idx == abort_at) begin
          cmd_abort = 1'b1;
          abort_pending = 1'b1;
          in_valid = 1'b0;
        end else if (idx < SLOTS) begin
          in_data = 8'(8'h10 + idx);
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    cmd_abort = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, done_base;
    int we_base [64];
    bit gd, ga;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_vec(), 32'h0);
    reset_n = 1'b1;
    preset(1'b0);

    // ---- idle command rules ----
    pulse(1'b1, 1'b1, 1'b0);
    check("idle_both_err", cmd_err, 1'b1);
    check("idle_both_busy", busy, 1'b0);
    @(negedge clk);
    check("err_one_cycle", cmd_err, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    check("idle_abort_noeffect", {busy, aborted, done}, 3'b000);

    // ---- 1: SAVE, ready held high ----
    out_ready = 1'b1;
    base = rx_q.size();
    pulse(1'b1, 1'b0, 1'b0);
    wait_end(200, 1'b0, gd, ga);
    check("t1_done", gd, 1'b1);
    check("t1_enable_in_fin", sst_enable, 1'b1);
    check_stream("t1", base);
    for (int k = 1; k < SLOTS; k++)
      if (base + k < rx_t.size())
        check("t1_spacing", rx_t[base + k] - rx_t[base + k - 1], RD_SETTLE + 1);
    if (base + SLOTS - 1 < rx_t.size())
      check("t1_done_timing", end_cyc, rx_t[base + SLOTS - 1] + 1);
    @(negedge clk);
    check("t1_enable_drop", {sst_enable, busy, done}, 3'b000);

    // ---- 2: SAVE, random out_ready ----
    preset(1'b1);
    out_ready = 1'b0;
    base = rx_q.size();
    pulse(1'b1, 1'b0, 1'b0);
    wait_end(2000, 1'b1, gd, ga);
    check("t2_done", gd, 1'b1);
    check_stream("t2", base);
    check("t2_hold_stable", hold_viol, 0);
    out_ready = 1'b1;

    // ---- 3: LOAD 10..1A ----
    preset(1'b0);
    for (int k = 0; k < 64; k++) we_base[k] = we_cnt[k];
    done_base = done_cnt;
    run_load(0, gd, ga);
    check("t3_done", {gd, ga}, 2'b10);
    @(negedge clk);
    for (int k = 0; k < SLOTS; k++) begin
      check("t3_we_cycles", we_cnt[k] - we_base[k], WR_HOLD);
      check("t3_slot", regs[k], 8'(8'h10 + k));
    end
    check("t3_slot_beyond", regs[SLOTS], 8'(8'hA0 + SLOTS));
    check("t3_done_once", done_cnt - done_base, 1);

    // ---- 4: LOAD aborted right after byte 3 enters the write hold ----
    preset(1'b0);
    for (int k = 0; k < 64; k++) we_base[k] = we_cnt[k];
    done_base = done_cnt;
    we_at_abort = 1'b0;
    run_load(4, gd, ga);
    check("t4_aborted", {gd, ga}, 2'b01);
    check("t4_we_before_abort", we_at_abort, 1'b1);
    check("t4_drop", {sst_we, in_ready, out_valid, done, busy}, 5'b00000);
    @(negedge clk);
    check("t4_aborted_pulse", aborted, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check("t4_slot_written", regs[k], 8'(8'h10 + k));
      check("t4_we_cycles", we_cnt[k] - we_base[k], WR_HOLD);
    end
    check("t4_slot3", regs[3], 8'h13);
    check("t4_slot3_we", we_cnt[3] - we_base[3], 1);
    for (int k = 4; k < SLOTS; k++) check("t4_slot_kept", regs[k], 8'(8'hA0 + k));
    check("t4_no_done", done_cnt - done_base, 0);

    // ---- 5: command errors, SAVE still completes ----
    preset(1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check("t5_both_err", {cmd_err, busy}, 2'b10);
    base = rx_q.size();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    check("t5_busy_err", {cmd_err, busy, in_ready}, 3'b110);
    wait_end(200, 1'b0, gd, ga);
    check("t5_done", gd, 1'b1);
    check_stream("t5", base);

    // ---- 6: async reset mid-SAVE at slot 5 ----
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (busy && sst_addr == 6'd5) break;
      @(negedge clk);
    end
    check("t6_mid_transfer", {busy, sst_addr}, {1'b1, 6'd5});
    #2 reset_n = 1'b0;
    #1 check("t6_async_reset", out_vec(), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base = rx_q.size();
    pulse(1'b1, 1'b0, 1'b0);
    check("t6_restart_addr", {busy, sst_addr}, {1'b1, 6'd0});
    wait_end(200, 1'b0, gd, ga);
    check("t6_done", gd, 1'b1);
    check_stream("t6", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
